// File: rtl/pipe_stage_regs_if.sv
// Bundle of the IF/ID, ID/EX and EX/MEM boundary register inputs and outputs.
interface pipe_stage_regs_if #(
    parameter int unsigned DW = 16
);
    // IF/ID bank
    logic [DW-1:0] if_id_pc_next_in,  if_id_pc_next_out;
    logic [DW-1:0] if_id_pc_cur_in,   if_id_pc_cur_out;
    logic [DW-1:0] if_id_instr_in,    if_id_instr_out;

    // ID/EX bank
    logic [DW-1:0] id_ex_rd1_in,             id_ex_rd1_out;
    logic [DW-1:0] id_ex_rd2_in,             id_ex_rd2_out;
    logic [DW-1:0] id_ex_four_ext_in,        id_ex_four_ext_out;
    logic [DW-1:0] id_ex_seven_ext_in,       id_ex_seven_ext_out;
    logic [DW-1:0] id_ex_shifted_in,         id_ex_shifted_out;
    logic [DW-1:0] id_ex_word_align_jump_in, id_ex_word_align_jump_out;
    logic [DW-1:0] id_ex_pc2_in,             id_ex_pc2_out;
    logic [2:0]    id_ex_alu_ctrl_in,        id_ex_alu_ctrl_out;
    logic [2:0]    id_ex_set_ctrl_in,        id_ex_set_ctrl_out;
    logic [2:0]    id_ex_write_reg_in,       id_ex_write_reg_out;
    logic [1:0]    id_ex_bsrc_in,            id_ex_bsrc_out;
    logic [1:0]    id_ex_branch_ctrl_in,     id_ex_branch_ctrl_out;
    logic [1:0]    id_ex_reg_src_in,         id_ex_reg_src_out;
    logic          id_ex_inva_in,            id_ex_inva_out;
    logic          id_ex_invb_in,            id_ex_invb_out;
    logic          id_ex_branch_in,          id_ex_branch_out;
    logic          id_ex_slbi_in,            id_ex_slbi_out;
    logic          id_ex_btr_in,             id_ex_btr_out;
    logic          id_ex_mem_wrt_in,         id_ex_mem_wrt_out;
    logic          id_ex_alu_jmp_in,         id_ex_alu_jmp_out;
    logic          id_ex_pc_or_add_in,       id_ex_pc_or_add_out;
    logic          id_ex_halt_in,            id_ex_halt_out;
    logic          id_ex_reg_wrt_in,         id_ex_reg_wrt_out;
    logic          id_ex_send_nop_in,        id_ex_send_nop_out;

    // EX/MEM bank
    logic [DW-1:0] ex_mem_alu_in,        ex_mem_alu_out;
    logic [DW-1:0] ex_mem_binput_in,     ex_mem_binput_out;
    logic [DW-1:0] ex_mem_sgn_ext_in,    ex_mem_sgn_ext_out;
    logic [DW-1:0] ex_mem_rd2_in,        ex_mem_rd2_out;
    logic [DW-1:0] ex_mem_pc2_in,        ex_mem_pc2_out;
    logic [DW-1:0] ex_mem_seven_ext_in,  ex_mem_seven_ext_out;
    logic [2:0]    ex_mem_write_reg_in,  ex_mem_write_reg_out;
    logic [1:0]    ex_mem_reg_src_in,    ex_mem_reg_src_out;
    logic          ex_mem_branchtake_in, ex_mem_branchtake_out;
    logic          ex_mem_branch_in,     ex_mem_branch_out;
    logic          ex_mem_pc_or_add_in,  ex_mem_pc_or_add_out;
    logic          ex_mem_alu_jmp_in,    ex_mem_alu_jmp_out;
    logic          ex_mem_mem_wrt_in,    ex_mem_mem_wrt_out;
    logic          ex_mem_halt_in,       ex_mem_halt_out;
    logic          ex_mem_reg_wrt_in,    ex_mem_reg_wrt_out;
    logic          ex_mem_send_nop_in,   ex_mem_send_nop_out;

    // Pipeline stages drive the *_in side and consume the *_out side.
    modport master (
        output if_id_pc_next_in, if_id_pc_cur_in, if_id_instr_in,
        output id_ex_rd1_in, id_ex_rd2_in, id_ex_four_ext_in, id_ex_seven_ext_in,
        output id_ex_shifted_in, id_ex_word_align_jump_in, id_ex_pc2_in,
        output id_ex_alu_ctrl_in, id_ex_set_ctrl_in, id_ex_write_reg_in,
        output id_ex_bsrc_in, id_ex_branch_ctrl_in, id_ex_reg_src_in,
        output id_ex_inva_in, id_ex_invb_in, id_ex_branch_in, id_ex_slbi_in,
        output id_ex_btr_in, id_ex_mem_wrt_in, id_ex_alu_jmp_in, id_ex_pc_or_add_in,
        output id_ex_halt_in, id_ex_reg_wrt_in, id_ex_send_nop_in,
        output ex_mem_alu_in, ex_mem_binput_in, ex_mem_sgn_ext_in, ex_mem_rd2_in,
        output ex_mem_pc2_in, ex_mem_seven_ext_in, ex_mem_write_reg_in, ex_mem_reg_src_in,
        output ex_mem_branchtake_in, ex_mem_branch_in, ex_mem_pc_or_add_in,
        output ex_mem_alu_jmp_in, ex_mem_mem_wrt_in, ex_mem_halt_in,
        output ex_mem_reg_wrt_in, ex_mem_send_nop_in,
        input  if_id_pc_next_out, if_id_pc_cur_out, if_id_instr_out,
        input  id_ex_rd1_out, id_ex_rd2_out, id_ex_four_ext_out, id_ex_seven_ext_out,
        input  id_ex_shifted_out, id_ex_word_align_jump_out, id_ex_pc2_out,
        input  id_ex_alu_ctrl_out, id_ex_set_ctrl_out, id_ex_write_reg_out,
        input  id_ex_bsrc_out, id_ex_branch_ctrl_out, id_ex_reg_src_out,
        input  id_ex_inva_out, id_ex_invb_out, id_ex_branch_out, id_ex_slbi_out,
        input  id_ex_btr_out, id_ex_mem_wrt_out, id_ex_alu_jmp_out, id_ex_pc_or_add_out,
        input  id_ex_halt_out, id_ex_reg_wrt_out, id_ex_send_nop_out,
        input  ex_mem_alu_out, ex_mem_binput_out, ex_mem_sgn_ext_out, ex_mem_rd2_out,
        input  ex_mem_pc2_out, ex_mem_seven_ext_out, ex_mem_write_reg_out, ex_mem_reg_src_out,
        input  ex_mem_branchtake_out, ex_mem_branch_out, ex_mem_pc_or_add_out,
        input  ex_mem_alu_jmp_out, ex_mem_mem_wrt_out, ex_mem_halt_out,
        input  ex_mem_reg_wrt_out, ex_mem_send_nop_out
    );

    // The register banks consume the *_in side and drive the *_out side.
    modport slave (
        input  if_id_pc_next_in, if_id_pc_cur_in, if_id_instr_in,
        input  id_ex_rd1_in, id_ex_rd2_in, id_ex_four_ext_in, id_ex_seven_ext_in,
        input  id_ex_shifted_in, id_ex_word_align_jump_in, id_ex_pc2_in,
        input  id_ex_alu_ctrl_in, id_ex_set_ctrl_in, id_ex_write_reg_in,
        input  id_ex_bsrc_in, id_ex_branch_ctrl_in, id_ex_reg_src_in,
        input  id_ex_inva_in, id_ex_invb_in, id_ex_branch_in, id_ex_slbi_in,
        input  id_ex_btr_in, id_ex_mem_wrt_in, id_ex_alu_jmp_in, id_ex_pc_or_add_in,
        input  id_ex_halt_in, id_ex_reg_wrt_in, id_ex_send_nop_in,
        input  ex_mem_alu_in, ex_mem_binput_in, ex_mem_sgn_ext_in, ex_mem_rd2_in,
        input  ex_mem_pc2_in, ex_mem_seven_ext_in, ex_mem_write_reg_in, ex_mem_reg_src_in,
        input  ex_mem_branchtake_in, ex_mem_branch_in, ex_mem_pc_or_add_in,
        input  ex_mem_alu_jmp_in, ex_mem_mem_wrt_in, ex_mem_halt_in,
        input  ex_mem_reg_wrt_in, ex_mem_send_nop_in,
        output if_id_pc_next_out, if_id_pc_cur_out, if_id_instr_out,
        output id_ex_rd1_out, id_ex_rd2_out, id_ex_four_ext_out, id_ex_seven_ext_out,
        output id_ex_shifted_out, id_ex_word_align_jump_out, id_ex_pc2_out,
        output id_ex_alu_ctrl_out, id_ex_set_ctrl_out, id_ex_write_reg_out,
        output id_ex_bsrc_out, id_ex_branch_ctrl_out, id_ex_reg_src_out,
        output id_ex_inva_out, id_ex_invb_out, id_ex_branch_out, id_ex_slbi_out,
        output id_ex_btr_out, id_ex_mem_wrt_out, id_ex_alu_jmp_out, id_ex_pc_or_add_out,
        output id_ex_halt_out, id_ex_reg_wrt_out, id_ex_send_nop_out,
        output ex_mem_alu_out, ex_mem_binput_out, ex_mem_sgn_ext_out, ex_mem_rd2_out,
        output ex_mem_pc2_out, ex_mem_seven_ext_out, ex_mem_write_reg_out, ex_mem_reg_src_out,
        output ex_mem_branchtake_out, ex_mem_branch_out, ex_mem_pc_or_add_out,
        output ex_mem_alu_jmp_out, ex_mem_mem_wrt_out, ex_mem_halt_out,
        output ex_mem_reg_wrt_out, ex_mem_send_nop_out
    );
endinterface

// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/MEM boundary registers of the 16-bit 5-stage CPU.
// Each bank is a plain free-running flop set: one cycle of latency, no
// enable/stall/flush. Bubbles are made upstream by dropping reg_wrt/mem_wrt.
module pipe_stage_regs #(
    parameter int unsigned DW = 16
) (
    input  logic               clk,
    input  logic               rst,    // asynchronous, active-low
    pipe_stage_regs_if.slave   bus
);
    // Decode must see a NOP rather than HALT (all zeros) coming out of reset.
    localparam logic [DW-1:0] NOP_INSTR = DW'(16'h0800);

    // IF/ID bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.if_id_pc_next_out <= '0;
            bus.if_id_pc_cur_out  <= '0;
            bus.if_id_instr_out   <= NOP_INSTR;
        end else begin
            bus.if_id_pc_next_out <= bus.if_id_pc_next_in;
            bus.if_id_pc_cur_out  <= bus.if_id_pc_cur_in;
            bus.if_id_instr_out   <= bus.if_id_instr_in;
        end
    end

    // ID/EX bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.id_ex_rd1_out             <= '0;
            bus.id_ex_rd2_out             <= '0;
            bus.id_ex_four_ext_out        <= '0;
            bus.id_ex_seven_ext_out       <= '0;
            bus.id_ex_shifted_out         <= '0;
            bus.id_ex_word_align_jump_out <= '0;
            bus.id_ex_pc2_out             <= '0;
            bus.id_ex_alu_ctrl_out        <= '0;
            bus.id_ex_set_ctrl_out        <= '0;
            bus.id_ex_write_reg_out       <= '0;
            bus.id_ex_bsrc_out            <= '0;
            bus.id_ex_branch_ctrl_out     <= '0;
            bus.id_ex_reg_src_out         <= '0;
            bus.id_ex_inva_out            <= 1'b0;
            bus.id_ex_invb_out            <= 1'b0;
            bus.id_ex_branch_out          <= 1'b0;
            bus.id_ex_slbi_out            <= 1'b0;
            bus.id_ex_btr_out             <= 1'b0;
            bus.id_ex_mem_wrt_out         <= 1'b0;
            bus.id_ex_alu_jmp_out         <= 1'b0;
            bus.id_ex_pc_or_add_out       <= 1'b0;
            bus.id_ex_halt_out            <= 1'b0;
            bus.id_ex_reg_wrt_out         <= 1'b0;
            bus.id_ex_send_nop_out        <= 1'b0;
        end else begin
            bus.id_ex_rd1_out             <= bus.id_ex_rd1_in;
            bus.id_ex_rd2_out             <= bus.id_ex_rd2_in;
            bus.id_ex_four_ext_out        <= bus.id_ex_four_ext_in;
            bus.id_ex_seven_ext_out       <= bus.id_ex_seven_ext_in;
            bus.id_ex_shifted_out         <= bus.id_ex_shifted_in;
            bus.id_ex_word_align_jump_out <= bus.id_ex_word_align_jump_in;
            bus.id_ex_pc2_out             <= bus.id_ex_pc2_in;
            bus.id_ex_alu_ctrl_out        <= bus.id_ex_alu_ctrl_in;
            bus.id_ex_set_ctrl_out        <= bus.id_ex_set_ctrl_in;
            bus.id_ex_write_reg_out       <= bus.id_ex_write_reg_in;
            bus.id_ex_bsrc_out            <= bus.id_ex_bsrc_in;
            bus.id_ex_branch_ctrl_out     <= bus.id_ex_branch_ctrl_in;
            bus.id_ex_reg_src_out         <= bus.id_ex_reg_src_in;
            bus.id_ex_inva_out            <= bus.id_ex_inva_in;
            bus.id_ex_invb_out            <= bus.id_ex_invb_in;
            bus.id_ex_branch_out          <= bus.id_ex_branch_in;
            bus.id_ex_slbi_out            <= bus.id_ex_slbi_in;
            bus.id_ex_btr_out             <= bus.id_ex_btr_in;
            bus.id_ex_mem_wrt_out         <= bus.id_ex_mem_wrt_in;
            bus.id_ex_alu_jmp_out         <= bus.id_ex_alu_jmp_in;
            bus.id_ex_pc_or_add_out       <= bus.id_ex_pc_or_add_in;
            bus.id_ex_halt_out            <= bus.id_ex_halt_in;
            bus.id_ex_reg_wrt_out         <= bus.id_ex_reg_wrt_in;
            bus.id_ex_send_nop_out        <= bus.id_ex_send_nop_in;
        end
    end

    // EX/MEM bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ex_mem_alu_out        <= '0;
            bus.ex_mem_binput_out     <= '0;
            bus.ex_mem_sgn_ext_out    <= '0;
            bus.ex_mem_rd2_out        <= '0;
            bus.ex_mem_pc2_out        <= '0;
            bus.ex_mem_seven_ext_out  <= '0;
            bus.ex_mem_write_reg_out  <= '0;
            bus.ex_mem_reg_src_out    <= '0;
            bus.ex_mem_branchtake_out <= 1'b0;
            bus.ex_mem_branch_out     <= 1'b0;
            bus.ex_mem_pc_or_add_out  <= 1'b0;
            bus.ex_mem_alu_jmp_out    <= 1'b0;
            bus.ex_mem_mem_wrt_out    <= 1'b0;
            bus.ex_mem_halt_out       <= 1'b0;
            bus.ex_mem_reg_wrt_out    <= 1'b0;
            bus.ex_mem_send_nop_out   <= 1'b0;
        end else begin
            bus.ex_mem_alu_out        <= bus.ex_mem_alu_in;
            bus.ex_mem_binput_out     <= bus.ex_mem_binput_in;
            bus.ex_mem_sgn_ext_out    <= bus.ex_mem_sgn_ext_in;
            bus.ex_mem_rd2_out        <= bus.ex_mem_rd2_in;
            bus.ex_mem_pc2_out        <= bus.ex_mem_pc2_in;
            bus.ex_mem_seven_ext_out  <= bus.ex_mem_seven_ext_in;
            bus.ex_mem_write_reg_out  <= bus.ex_mem_write_reg_in;
            bus.ex_mem_reg_src_out    <= bus.ex_mem_reg_src_in;
            bus.ex_mem_branchtake_out <= bus.ex_mem_branchtake_in;
            bus.ex_mem_branch_out     <= bus.ex_mem_branch_in;
            bus.ex_mem_pc_or_add_out  <= bus.ex_mem_pc_or_add_in;
            bus.ex_mem_alu_jmp_out    <= bus.ex_mem_alu_jmp_in;
            bus.ex_mem_mem_wrt_out    <= bus.ex_mem_mem_wrt_in;
            bus.ex_mem_halt_out       <= bus.ex_mem_halt_in;
            bus.ex_mem_reg_wrt_out    <= bus.ex_mem_reg_wrt_in;
            bus.ex_mem_send_nop_out   <= bus.ex_mem_send_nop_in;
        end
    end
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for the three pipeline boundary register banks.
module tb_pipe_stage_regs;
    localparam int unsigned DW = 16;
    localparam int unsigned VW = 295;   // total bits across all banks

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [VW-1:0] rst_val;

    pipe_stage_regs_if #(.DW(DW)) bus ();

    pipe_stage_regs #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every *_in field from one flat vector (field order matches outs()).
    task automatic drive_all(input logic [VW-1:0] v);
        {bus.if_id_pc_next_in, bus.if_id_pc_cur_in, bus.if_id_instr_in,
         bus.id_ex_rd1_in, bus.id_ex_rd2_in, bus.id_ex_four_ext_in, bus.id_ex_seven_ext_in,
         bus.id_ex_shifted_in, bus.id_ex_word_align_jump_in, bus.id_ex_pc2_in,
         bus.id_ex_alu_ctrl_in, bus.id_ex_set_ctrl_in, bus.id_ex_write_reg_in,
         bus.id_ex_bsrc_in, bus.id_ex_branch_ctrl_in, bus.id_ex_reg_src_in,
         bus.id_ex_inva_in, bus.id_ex_invb_in, bus.id_ex_branch_in, bus.id_ex_slbi_in,
         bus.id_ex_btr_in, bus.id_ex_mem_wrt_in, bus.id_ex_alu_jmp_in, bus.id_ex_pc_or_add_in,
         bus.id_ex_halt_in, bus.id_ex_reg_wrt_in, bus.id_ex_send_nop_in,
         bus.ex_mem_alu_in, bus.ex_mem_binput_in, bus.ex_mem_sgn_ext_in, bus.ex_mem_rd2_in,
         bus.ex_mem_pc2_in, bus.ex_mem_seven_ext_in, bus.ex_mem_write_reg_in, bus.ex_mem_reg_src_in,
         bus.ex_mem_branchtake_in, bus.ex_mem_branch_in, bus.ex_mem_pc_or_add_in,
         bus.ex_mem_alu_jmp_in, bus.ex_mem_mem_wrt_in, bus.ex_mem_halt_in,
         bus.ex_mem_reg_wrt_in, bus.ex_mem_send_nop_in} = v;
    endtask

    // Gather every *_out field into one flat vector.
    function automatic logic [VW-1:0] outs();
        return {bus.if_id_pc_next_out, bus.if_id_pc_cur_out, bus.if_id_instr_out,
         bus.id_ex_rd1_out, bus.id_ex_rd2_out, bus.id_ex_four_ext_out, bus.id_ex_seven_ext_out,
         bus.id_ex_shifted_out, bus.id_ex_word_align_jump_out, bus.id_ex_pc2_out,
         bus.id_ex_alu_ctrl_out, bus.id_ex_set_ctrl_out, bus.id_ex_write_reg_out,
         bus.id_ex_bsrc_out, bus.id_ex_branch_ctrl_out, bus.id_ex_reg_src_out,
         bus.id_ex_inva_out, bus.id_ex_invb_out, bus.id_ex_branch_out, bus.id_ex_slbi_out,
         bus.id_ex_btr_out, bus.id_ex_mem_wrt_out, bus.id_ex_alu_jmp_out, bus.id_ex_pc_or_add_out,
         bus.id_ex_halt_out, bus.id_ex_reg_wrt_out, bus.id_ex_send_nop_out,
         bus.ex_mem_alu_out, bus.ex_mem_binput_out, bus.ex_mem_sgn_ext_out, bus.ex_mem_rd2_out,
         bus.ex_mem_pc2_out, bus.ex_mem_seven_ext_out, bus.ex_mem_write_reg_out, bus.ex_mem_reg_src_out,
         bus.ex_mem_branchtake_out, bus.ex_mem_branch_out, bus.ex_mem_pc_or_add_out,
         bus.ex_mem_alu_jmp_out, bus.ex_mem_mem_wrt_out, bus.ex_mem_halt_out,
         bus.ex_mem_reg_wrt_out, bus.ex_mem_send_nop_out};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        return t[VW-1:0];
    endfunction

    // Reset with random inputs, then release and confirm the hold until the next edge.
    task automatic test_reset();
        logic [VW-1:0] v;
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v = rand_vec();
            drive_all(v);
            @(posedge clk);
            #1;
            vectors++;
            if (outs() !== rst_val) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, outs(), rst_val);
            end
        end
        vectors++;
        if (bus.if_id_instr_out !== 16'h0800) begin
            miscompares++;
            $display("FAIL reset_nop_instr: got %h expected 0800", bus.if_id_instr_out);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #2;
        vectors++;
        if (outs() !== rst_val) begin
            miscompares++;
            $display("FAIL reset_release_hold: got %h expected %h", outs(), rst_val);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (outs() !== v) begin
            miscompares++;
            $display("FAIL reset_release_track: got %h expected %h", outs(), v);
        end
    endtask

    // Single fetch capture: one-cycle latency, stable across the cycle, no comb path.
    task automatic test_basic();
        @(negedge clk);
        drive_all('0);
        bus.if_id_instr_in   = 16'hC001;
        bus.if_id_pc_next_in = 16'h0002;
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.if_id_instr_out, bus.if_id_pc_next_out} !== {16'hC001, 16'h0002}) begin
            miscompares++;
            $display("FAIL basic_capture: got %h %h expected c001 0002",
                     bus.if_id_instr_out, bus.if_id_pc_next_out);
        end
        bus.if_id_instr_in   = 16'h1234;
        bus.if_id_pc_next_in = 16'hFFFF;
        @(negedge clk);
        #3;
        vectors++;
        if ({bus.if_id_instr_out, bus.if_id_pc_next_out} !== {16'hC001, 16'h0002}) begin
            miscompares++;
            $display("FAIL basic_stable: got %h %h expected c001 0002",
                     bus.if_id_instr_out, bus.if_id_pc_next_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.if_id_instr_out, bus.if_id_pc_next_out} !== {16'h1234, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL basic_next: got %h %h expected 1234 ffff",
                     bus.if_id_instr_out, bus.if_id_pc_next_out);
        end
    endtask

    // Walking 1s then walking 0s over every bit of every field.
    task automatic test_walk();
        logic [VW-1:0] v;
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < VW; b++) begin
                v = '0;
                v[b] = 1'b1;
                if (w == 1) v = ~v;
                @(negedge clk);
                drive_all(v);
                @(posedge clk);
                #1;
                vectors++;
                if (outs() !== v) begin
                    miscompares++;
                    $display("FAIL walk%0d_bit%0d: got %h expected %h", w, b, outs(), v);
                end
            end
        end
    endtask

    // Field patterns across random backgrounds.
    task automatic test_patterns();
        logic [VW-1:0] v;
        for (int i = 0; i < 6; i++) begin
            v = (i < 2) ? {19{(i == 0) ? 16'hA5A5 : 16'h5A5A}} : rand_vec();
            @(negedge clk);
            drive_all(v);
            @(posedge clk);
            #1;
            vectors++;
            if (outs() !== v) begin
                miscompares++;
                $display("FAIL pattern[%0d]: got %h expected %h", i, outs(), v);
            end
        end
    endtask

    // Three-instruction sequence with id_ex outputs chained into ex_mem inputs.
    task automatic test_back_to_back();
        logic        halt_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        nop_seq  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] pc_seq   [6] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A, 16'h000C};
        logic [15:0] ins_seq  [6] = '{16'h4A21, 16'hC001, 16'h0000, 16'h0800, 16'h0800, 16'h0800};
        logic        halt_prev, nop_prev;
        logic [15:0] pc_prev;
        @(negedge clk);
        drive_all('0);
        @(posedge clk);
        halt_prev = 1'b0;
        nop_prev  = 1'b0;
        pc_prev   = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.if_id_instr_in     = ins_seq[k];
            bus.id_ex_halt_in      = halt_seq[k];
            bus.id_ex_send_nop_in  = nop_seq[k];
            bus.id_ex_pc2_in       = pc_seq[k];
            bus.ex_mem_halt_in     = bus.id_ex_halt_out;
            bus.ex_mem_send_nop_in = bus.id_ex_send_nop_out;
            bus.ex_mem_pc2_in      = bus.id_ex_pc2_out;
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.id_ex_halt_out, bus.ex_mem_halt_out, bus.id_ex_send_nop_out, bus.ex_mem_send_nop_out}
                !== {halt_seq[k], halt_prev, nop_seq[k], nop_prev}) begin
                miscompares++;
                $display("FAIL chain_flags[%0d]: got %b%b%b%b expected %b%b%b%b", k,
                         bus.id_ex_halt_out, bus.ex_mem_halt_out, bus.id_ex_send_nop_out,
                         bus.ex_mem_send_nop_out, halt_seq[k], halt_prev, nop_seq[k], nop_prev);
            end
            vectors++;
            if ({bus.id_ex_pc2_out, bus.ex_mem_pc2_out} !== {pc_seq[k], pc_prev}) begin
                miscompares++;
                $display("FAIL chain_pc2[%0d]: got %h %h expected %h %h", k,
                         bus.id_ex_pc2_out, bus.ex_mem_pc2_out, pc_seq[k], pc_prev);
            end
            vectors++;
            if (bus.if_id_instr_out !== ins_seq[k]) begin
                miscompares++;
                $display("FAIL chain_instr[%0d]: got %h expected %h", k, bus.if_id_instr_out, ins_seq[k]);
            end
            halt_prev = halt_seq[k];
            nop_prev  = nop_seq[k];
            pc_prev   = pc_seq[k];
        end
    endtask

    // Reset asserted between edges clears everything at once and holds while low.
    task automatic test_async_reset();
        logic [VW-1:0] ones;
        ones = '1;
        @(negedge clk);
        drive_all(ones);
        @(posedge clk);
        #1;
        vectors++;
        if (outs() !== ones) begin
            miscompares++;
            $display("FAIL async_preload: got %h expected %h", outs(), ones);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (outs() !== rst_val) begin
            miscompares++;
            $display("FAIL async_immediate: got %h expected %h", outs(), rst_val);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (outs() !== rst_val) begin
                miscompares++;
                $display("FAIL async_held[%0d]: got %h expected %h", i, outs(), rst_val);
            end
        end
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (outs() !== ones) begin
            miscompares++;
            $display("FAIL async_recover: got %h expected %h", outs(), ones);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_val     = '0;
        rst_val[VW-33 -: 16] = 16'h0800;
        drive_all('0);
        test_reset();
        test_basic();
        test_walk();
        test_patterns();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Bundles the three front pipeline boundary registers of the 16-bit WISC-style 5-stage CPU: IF/ID, ID/EX and EX/MEM.
- Each bank is a free-running set of D flops that captures its stage's outputs on every rising clock edge. It presents them to the next stage one cycle later.
- There is no combinational path from any input to any output. Banks are independent; the top level chains them, e.g. id_ex outputs feed execute and ex_mem inputs.

Parameters:
- DW, 16, datapath/PC/instruction width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- if_id_pc_next_in / if_id_pc_next_out  in/out  DW  PC+2 from fetch.
- if_id_pc_cur_in / if_id_pc_cur_out  in/out  DW  PC of the fetched instruction (no +2).
- if_id_instr_in / if_id_instr_out  in/out  DW  fetched instruction.
- id_ex_{rd1,rd2,four_ext,seven_ext,shifted,word_align_jump,pc2}_in / _out  in/out  DW each  register reads, 4-bit and 7-bit sign-extended immediates, SLBI shift operand, jump displacement, PC+2.
- id_ex_{alu_ctrl,set_ctrl}_in / _out  in/out  3 each  ALU op, set-condition select.
- id_ex_write_reg_in / _out  in/out  3  destination register.
- id_ex_{bsrc,branch_ctrl,reg_src}_in / _out  in/out  2 each  B-operand select, branch condition, writeback source.
- id_ex_{inva,invb,branch,slbi,btr,mem_wrt,alu_jmp,pc_or_add,halt,reg_wrt,send_nop}_in / _out  in/out  1 each  decode control flags.
- ex_mem_{alu,binput,sgn_ext,rd2,pc2,seven_ext}_in / _out  in/out  DW each  ALU result, B operand, jump displacement, store data, PC+2, 7-bit immediate.
- ex_mem_write_reg_in / _out  in/out  3  destination register.
- ex_mem_reg_src_in / _out  in/out  2  writeback source.
- ex_mem_{branchtake,branch,pc_or_add,alu_jmp,mem_wrt,halt,reg_wrt,send_nop}_in / _out  in/out  1 each  control flags.

Behaviour:
- Every *_out equals its *_in sampled at the previous rising clk edge. Latency is exactly 1 cycle per bank.
- There is no enable, stall or flush input. Bubbles are created upstream by forcing reg_wrt/mem_wrt low. send_nop is carried unchanged for the hazard comparator.
- Reset takes effect asynchronously the moment rst falls. It does not wait for a clock edge and overrides any coincident edge.
- Reset values: all outputs 0, except if_id_instr_out = 16'h0800 (NOP, opcode 00001), so decode sees a NOP rather than HALT (0x0000) out of reset.
- Reset therefore forces halt, mem_wrt, reg_wrt, branch, branchtake, alu_jmp, pc_or_add and send_nop to 0 in all banks, so no architectural side effect occurs.
- On rst rising (deassert), outputs hold their reset values until the next rising clk edge, then track the inputs.
- Reset mid-operation: all in-flight stage contents are discarded immediately.
- X on an input propagates only to its own output; banks share no state.

Test Plan:
- Hold rst=0 with random inputs → all outputs 0, if_id_instr_out=16'h0800. Then release rst: outputs unchanged until the next posedge.
- rst=1, drive if_id_instr_in=16'hC001, pc_next_in=16'h0002 at negedge → both visible on outputs after the next posedge and stable for the full cycle.
- Drive a 3-instruction sequence through all banks; top chains id_ex→ex_mem. id_ex_halt_in=1 in cycle N → id_ex_halt_out=1 in N+1, ex_mem_halt_out=1 in N+2 (chained).
- Per field, walk 1s/0s (e.g. 16'hA5A5 then 16'h5A5A on each DW field, 3'b101 on write_reg, 2'b10 on the 2-bit fields) → exact bitwise copy with no cross-field leakage.
- Assert rst low midway between clock edges with reg_wrt/mem_wrt=1 in every bank → outputs clear immediately, not at the next edge, and stay cleared while rst=0.
- Hold send_nop=1 on id_ex for 2 cycles then 0 → id_ex_send_nop_out follows with 1-cycle lag; ex_mem_send_nop_out follows with 2-cycle lag when chained.
